// File: rtl/vp_pkg.sv
// Shared constants and types for the crop/scale configuration controller.
package vp_pkg;

    localparam logic [2:0] A_START  = 3'd0;
    localparam logic [2:0] A_END    = 3'd1;
    localparam logic [2:0] A_OUTRES = 3'd2;
    localparam logic [2:0] A_CTRL   = 3'd3;
    localparam logic [2:0] A_STATUS = 3'd4;
    localparam logic [2:0] A_XSCALE = 3'd5;
    localparam logic [2:0] A_YSCALE = 3'd6;

    localparam int SCALE_INT_W  = 4;
    localparam int SCALE_FRAC_W = 14;
    localparam int SCALE_W      = SCALE_INT_W + SCALE_FRAC_W;
    localparam int CROP_W       = 12;

    localparam logic [SCALE_W-1:0] SCALE_UNITY = 18'h04000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV_X,
        ST_DIV_Y,
        ST_READY
    } state_t;

endpackage

// File: rtl/vp_seq_div.sv
// Restoring divider, one quotient bit per cycle. o_done flags the last
// iteration; the final quotient is presented combinationally with it.
module vp_seq_div #(
    parameter int DVD_W = 26,
    parameter int DVS_W = 12,
    parameter int Q_W   = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [DVD_W-1:0] i_dividend,
    input  logic [DVS_W-1:0] i_divisor,
    output logic             o_done,
    output logic [Q_W-1:0]   o_quot,
    output logic             o_sat
);

    localparam int CW = $clog2(DVD_W);

    logic             r_busy;
    logic [CW-1:0]    r_cnt;
    logic [DVD_W-1:0] r_dvd;
    logic [DVS_W-1:0] r_dvs;
    logic [DVS_W-1:0] r_rem;
    logic [DVD_W-2:0] r_quo;

    logic [DVS_W:0]   w_trial;
    logic [DVS_W-1:0] w_diff;
    logic             w_ge;
    logic [DVS_W-1:0] w_rem_n;
    logic [DVD_W-1:0] w_quo_n;

    assign w_trial = {r_rem, r_dvd[DVD_W-1]};
    assign w_ge    = w_trial >= {1'b0, r_dvs};
    assign w_diff  = w_trial[DVS_W-1:0] - r_dvs;
    assign w_rem_n = w_ge ? w_diff : w_trial[DVS_W-1:0];
    assign w_quo_n = {r_quo, w_ge};

    assign o_done = r_busy && (r_cnt == CW'(DVD_W - 1));
    assign o_sat  = |w_quo_n[DVD_W-1:Q_W];
    assign o_quot = o_sat ? '1 : w_quo_n[Q_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_dvd  <= '0;
            r_dvs  <= '0;
            r_rem  <= '0;
            r_quo  <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            r_dvd  <= i_dividend;
            r_dvs  <= i_divisor;
            r_rem  <= '0;
            r_quo  <= '0;
        end else if (r_busy) begin
            r_dvd <= {r_dvd[DVD_W-2:0], 1'b0};
            r_rem <= w_rem_n;
            r_quo <= w_quo_n[DVD_W-2:0];
            r_cnt <= r_cnt + CW'(1);
            if (o_done) r_busy <= 1'b0;
        end
    end

endmodule

// File: rtl/vp_scale_ctrl.sv
// Shadow crop/resolution registers, sequential scale computation and
// vsync-aligned atomic swap into the cut/scaler configuration.
module vp_scale_ctrl
    import vp_pkg::*;
#(
    parameter int H_DISP          = 1280,
    parameter int V_DISP          = 720,
    parameter int RES_WIDTH       = 11,
    parameter int SCALE_INT_BITS  = SCALE_INT_W,
    parameter int SCALE_FRAC_BITS = SCALE_FRAC_W
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    reg_we,
    input  logic [2:0]                              reg_addr,
    input  logic [31:0]                             reg_wdata,
    output logic [31:0]                             reg_rdata,
    input  logic                                    vs_i,
    output logic [11:0]                             start_x,
    output logic [11:0]                             start_y,
    output logic [11:0]                             end_x,
    output logic [11:0]                             end_y,
    output logic [RES_WIDTH-1:0]                    input_x_res,
    output logic [RES_WIDTH-1:0]                    input_y_res,
    output logic [RES_WIDTH-1:0]                    output_x_res,
    output logic [RES_WIDTH-1:0]                    output_y_res,
    output logic [SCALE_INT_BITS+SCALE_FRAC_BITS-1:0] x_scale,
    output logic [SCALE_INT_BITS+SCALE_FRAC_BITS-1:0] y_scale,
    output logic                                    nearest_neighbor,
    output logic                                    scaler_start,
    output logic                                    cfg_busy,
    output logic                                    cfg_pending,
    output logic                                    cfg_err,
    output logic                                    cfg_sat
);

    localparam int SB    = SCALE_INT_BITS + SCALE_FRAC_BITS;
    localparam int DVD_W = CROP_W + SCALE_FRAC_BITS;
    localparam int DVS_W = RES_WIDTH + 1;

    localparam logic [CROP_W-1:0]    HMAX  = CROP_W'(H_DISP);
    localparam logic [CROP_W-1:0]    VMAX  = CROP_W'(V_DISP);
    localparam logic [RES_WIDTH-1:0] HRES  = RES_WIDTH'(H_DISP - 1);
    localparam logic [RES_WIDTH-1:0] VRES  = RES_WIDTH'(V_DISP - 1);
    localparam logic [SB-1:0]        UNITY = SB'(SCALE_UNITY);

    state_t r_state, w_state_n;

    logic [CROP_W-1:0]    r_sh_sx, r_sh_sy, r_sh_ex, r_sh_ey;
    logic [RES_WIDTH-1:0] r_sh_ox, r_sh_oy;
    logic                 r_enable, r_sh_nn;

    logic [CROP_W-1:0]    r_cp_sx, r_cp_sy, r_cp_ex, r_cp_ey;
    logic [RES_WIDTH-1:0] r_cp_ox, r_cp_oy;
    logic [SB-1:0]        r_xq, r_yq;

    logic [CROP_W-1:0]    r_sx, r_sy, r_ex, r_ey;
    logic [RES_WIDTH-1:0] r_ix, r_iy, r_ox, r_oy;
    logic [SB-1:0]        r_xs, r_ys;
    logic                 r_nn;

    logic        r_err, r_sat, r_vs_d, r_sc_start;
    logic [31:0] r_rdata, w_rdata;

    logic             w_commit, w_valid, w_go, w_vs_rise, w_swap;
    logic             w_busy, w_pending;
    logic             w_div_start, w_div_done, w_div_sat;
    logic [SB-1:0]    w_quot;
    logic [DVD_W-1:0] w_dvd;
    logic [DVS_W-1:0] w_dvs;
    logic             w_unused;

    assign w_unused = &{1'b0, reg_wdata[31:28], reg_wdata[15:12]};

    assign w_commit  = reg_we && (reg_addr == A_CTRL) && reg_wdata[2];
    assign w_valid   = (r_sh_ex > r_sh_sx) && (r_sh_ey > r_sh_sy)
                    && (r_sh_ex <= HMAX) && (r_sh_ey <= VMAX);
    assign w_go      = w_commit && w_valid;
    assign w_vs_rise = vs_i && !r_vs_d;
    assign w_swap    = (r_state == ST_READY) && w_vs_rise && r_enable;
    assign w_busy    = (r_state == ST_DIV_X) || (r_state == ST_DIV_Y);
    assign w_pending = (r_state == ST_READY);

    // X always starts from the live shadows on commit; Y from the capture.
    assign w_dvd = w_go
        ? {r_sh_ex - r_sh_sx, {SCALE_FRAC_BITS{1'b0}}}
        : {r_cp_ey - r_cp_sy, {SCALE_FRAC_BITS{1'b0}}};
    assign w_dvs = w_go
        ? {1'b0, r_sh_ox} + DVS_W'(1)
        : {1'b0, r_cp_oy} + DVS_W'(1);

    vp_seq_div #(
        .DVD_W (DVD_W),
        .DVS_W (DVS_W),
        .Q_W   (SB)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_div_start),
        .i_dividend (w_dvd),
        .i_divisor  (w_dvs),
        .o_done     (w_div_done),
        .o_quot     (w_quot),
        .o_sat      (w_div_sat)
    );

    always_comb begin
        w_state_n   = r_state;
        w_div_start = 1'b0;
        case (r_state)
            ST_DIV_X: begin
                if (w_div_done) begin
                    w_state_n   = ST_DIV_Y;
                    w_div_start = 1'b1;
                end
            end
            ST_DIV_Y: if (w_div_done) w_state_n = ST_READY;
            ST_READY: if (w_swap) w_state_n = ST_IDLE;
            default: ;
        endcase
        if (w_go) begin
            w_state_n   = ST_DIV_X;
            w_div_start = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_n;
    end

    always_comb begin
        w_rdata = '0;
        case (reg_addr)
            A_START:  w_rdata = {4'h0, r_sh_sy, 4'h0, r_sh_sx};
            A_END:    w_rdata = {4'h0, r_sh_ey, 4'h0, r_sh_ex};
            A_OUTRES: begin
                w_rdata[RES_WIDTH-1:0]  = r_sh_ox;
                w_rdata[16+:RES_WIDTH]  = r_sh_oy;
            end
            A_CTRL:   w_rdata[1:0] = {r_sh_nn, r_enable};
            A_STATUS: w_rdata[3:0] = {r_sat, r_err, w_pending, w_busy};
            A_XSCALE: w_rdata[SB-1:0] = r_xs;
            A_YSCALE: w_rdata[SB-1:0] = r_ys;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh_sx  <= '0;
            r_sh_sy  <= '0;
            r_sh_ex  <= HMAX;
            r_sh_ey  <= VMAX;
            r_sh_ox  <= HRES;
            r_sh_oy  <= VRES;
            r_enable <= 1'b0;
            r_sh_nn  <= 1'b1;
            r_rdata  <= '0;
        end else begin
            r_rdata <= w_rdata;
            if (reg_we) begin
                case (reg_addr)
                    A_START: begin
                        r_sh_sx <= reg_wdata[11:0];
                        r_sh_sy <= reg_wdata[27:16];
                    end
                    A_END: begin
                        r_sh_ex <= reg_wdata[11:0];
                        r_sh_ey <= reg_wdata[27:16];
                    end
                    A_OUTRES: begin
                        r_sh_ox <= reg_wdata[RES_WIDTH-1:0];
                        r_sh_oy <= reg_wdata[16+:RES_WIDTH];
                    end
                    A_CTRL: begin
                        r_enable <= reg_wdata[0];
                        r_sh_nn  <= reg_wdata[1];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cp_sx    <= '0;
            r_cp_sy    <= '0;
            r_cp_ex    <= HMAX;
            r_cp_ey    <= VMAX;
            r_cp_ox    <= HRES;
            r_cp_oy    <= VRES;
            r_xq       <= UNITY;
            r_yq       <= UNITY;
            r_err      <= 1'b0;
            r_sat      <= 1'b0;
            r_vs_d     <= 1'b0;
            r_sc_start <= 1'b0;
        end else begin
            r_vs_d     <= vs_i;
            r_sc_start <= w_vs_rise && r_enable;
            if ((r_state == ST_DIV_X) && w_div_done) begin
                r_xq <= w_quot;
                if (w_div_sat) r_sat <= 1'b1;
            end
            if ((r_state == ST_DIV_Y) && w_div_done) begin
                r_yq <= w_quot;
                if (w_div_sat) r_sat <= 1'b1;
            end
            // A commit outranks a same-cycle divider completion.
            if (w_commit) begin
                if (w_valid) begin
                    r_err   <= 1'b0;
                    r_sat   <= 1'b0;
                    r_cp_sx <= r_sh_sx;
                    r_cp_sy <= r_sh_sy;
                    r_cp_ex <= r_sh_ex;
                    r_cp_ey <= r_sh_ey;
                    r_cp_ox <= r_sh_ox;
                    r_cp_oy <= r_sh_oy;
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sx <= '0;
            r_sy <= '0;
            r_ex <= HMAX;
            r_ey <= VMAX;
            r_ix <= HRES;
            r_iy <= VRES;
            r_ox <= HRES;
            r_oy <= VRES;
            r_xs <= UNITY;
            r_ys <= UNITY;
            r_nn <= 1'b1;
        end else if (w_swap) begin
            r_sx <= r_cp_sx;
            r_sy <= r_cp_sy;
            r_ex <= r_cp_ex;
            r_ey <= r_cp_ey;
            r_ix <= RES_WIDTH'(r_cp_ex - r_cp_sx - 12'd1);
            r_iy <= RES_WIDTH'(r_cp_ey - r_cp_sy - 12'd1);
            r_ox <= r_cp_ox;
            r_oy <= r_cp_oy;
            r_xs <= r_xq;
            r_ys <= r_yq;
            r_nn <= r_sh_nn;
        end
    end

    assign reg_rdata        = r_rdata;
    assign start_x          = r_sx;
    assign start_y          = r_sy;
    assign end_x            = r_ex;
    assign end_y            = r_ey;
    assign input_x_res      = r_ix;
    assign input_y_res      = r_iy;
    assign output_x_res     = r_ox;
    assign output_y_res     = r_oy;
    assign x_scale          = r_xs;
    assign y_scale          = r_ys;
    assign nearest_neighbor = r_nn;
    assign scaler_start     = r_sc_start;
    assign cfg_busy         = w_busy;
    assign cfg_pending      = w_pending;
    assign cfg_err          = r_err;
    assign cfg_sat          = r_sat;

endmodule

// File: tb/tb_vp_scale_ctrl.sv
// Directed plus randomized checks of vp_scale_ctrl against an arithmetic
// model of the crop window and Q4.14 scale factors.
module tb_vp_scale_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reg_we = 1'b0;
    logic [2:0]  reg_addr = 3'd0;
    logic [31:0] reg_wdata = 32'd0;
    logic [31:0] reg_rdata;
    logic        vs_i = 1'b0;
    logic [11:0] start_x, start_y, end_x, end_y;
    logic [10:0] input_x_res, input_y_res, output_x_res, output_y_res;
    logic [17:0] x_scale, y_scale;
    logic        nearest_neighbor, scaler_start;
    logic        cfg_busy, cfg_pending, cfg_err, cfg_sat;

    vp_scale_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .reg_we           (reg_we),
        .reg_addr         (reg_addr),
        .reg_wdata        (reg_wdata),
        .reg_rdata        (reg_rdata),
        .vs_i             (vs_i),
        .start_x          (start_x),
        .start_y          (start_y),
        .end_x            (end_x),
        .end_y            (end_y),
        .input_x_res      (input_x_res),
        .input_y_res      (input_y_res),
        .output_x_res     (output_x_res),
        .output_y_res     (output_y_res),
        .x_scale          (x_scale),
        .y_scale          (y_scale),
        .nearest_neighbor (nearest_neighbor),
        .scaler_start     (scaler_start),
        .cfg_busy         (cfg_busy),
        .cfg_pending      (cfg_pending),
        .cfg_err          (cfg_err),
        .cfg_sat          (cfg_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sx; int sy; int ex; int ey; int ox; int oy;
    } cfg_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    cfg_t dflt = '{0, 0, 1280, 720, 1279, 719};
    cfg_t act, pend, sh, c;
    bit   act_nn;
    bit   sh_nn;

    function automatic longint rawq(int w, int o);
        return (longint'(w) * 16384) / longint'(o + 1);
    endfunction

    function automatic int scl(int w, int o);
        longint q;
        q = rawq(w, o);
        return (q >= 262144) ? 262143 : int'(q);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        reg_we    = 1'b1;
        reg_addr  = a;
        reg_wdata = d;
        @(negedge clk);
        reg_we    = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        reg_addr = a;
        @(negedge clk);
        d = reg_rdata;
    endtask

    task automatic set_cfg(input cfg_t k);
        wr(3'd0, {4'h0, 12'(k.sy), 4'h0, 12'(k.sx)});
        wr(3'd1, {4'h0, 12'(k.ey), 4'h0, 12'(k.ex)});
        wr(3'd2, {5'h0, 11'(k.oy), 5'h0, 11'(k.ox)});
        sh = k;
    endtask

    task automatic commit(input bit nn);
        wr(3'd3, {29'd0, 1'b1, nn, 1'b1});
        sh_nn = nn;
    endtask

    task automatic vs_pulse();
        vs_i = 1'b1;
        @(negedge clk);
        vs_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int exp_len);
        int n;
        n = 0;
        while (cfg_busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk(tag, n, exp_len);
    endtask

    task automatic check_active(input string t);
        chk({t, ".sx"}, start_x, act.sx);
        chk({t, ".sy"}, start_y, act.sy);
        chk({t, ".ex"}, end_x, act.ex);
        chk({t, ".ey"}, end_y, act.ey);
        chk({t, ".ixr"}, input_x_res, act.ex - act.sx - 1);
        chk({t, ".iyr"}, input_y_res, act.ey - act.sy - 1);
        chk({t, ".oxr"}, output_x_res, act.ox);
        chk({t, ".oyr"}, output_y_res, act.oy);
        chk({t, ".xs"}, x_scale, scl(act.ex - act.sx, act.ox));
        chk({t, ".ys"}, y_scale, scl(act.ey - act.sy, act.oy));
        chk({t, ".nn"}, nearest_neighbor, act_nn);
    endtask

    initial begin
        logic [31:0] d;
        bit          exp_sat;

        act    = dflt;
        sh     = dflt;
        act_nn = 1'b1;
        sh_nn  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state.
        check_active("rst0");
        chk("rst0.busy", cfg_busy, 0);
        chk("rst0.pend", cfg_pending, 0);
        chk("rst0.err", cfg_err, 0);
        chk("rst0.sat", cfg_sat, 0);
        chk("rst0.rdata", reg_rdata, 0);
        rd(3'd4, d);
        chk("rst0.status", d, 0);
        rd(3'd5, d);
        chk("rst0.xscale", d, 32'h4000);
        rd(3'd3, d);
        chk("rst0.ctrl", d, 32'h2);
        vs_pulse();
        chk("dis.start", scaler_start, 0);
        @(negedge clk);
        chk("dis.start2", scaler_start, 0);

        // Centre crop at half size back to 1280x720.
        c = '{320, 180, 960, 540, 1279, 719};
        set_cfg(c);
        commit(1'b0);
        pend = c;
        chk("crop.busy1", cfg_busy, 1);
        wait_idle("crop.blen", 52);
        chk("crop.pend", cfg_pending, 1);
        rd(3'd4, d);
        chk("crop.status", d, 32'h2);
        chk("crop.oldxs", x_scale, 32'h4000);
        vs_pulse();
        act = pend;
        act_nn = sh_nn;
        check_active("crop");
        chk("crop.xs_c", x_scale, 32'h2000);
        chk("crop.start", scaler_start, 1);
        chk("crop.pend0", cfg_pending, 0);
        @(negedge clk);
        chk("crop.start0", scaler_start, 0);
        rd(3'd6, d);
        chk("crop.ysr", d, 32'h2000);

        // Inverted X window is rejected.
        c = act;
        c.sx = 200;
        c.ex = 100;
        set_cfg(c);
        commit(1'b0);
        chk("bad.err", cfg_err, 1);
        chk("bad.busy", cfg_busy, 0);
        @(negedge clk);
        chk("bad.busy2", cfg_busy, 0);
        check_active("bad");

        // Random windows and output sizes.
        for (int i = 0; i < 4; i++) begin
            c.sx = $urandom_range(1200, 0);
            c.ex = $urandom_range(1280, c.sx + 1);
            c.sy = $urandom_range(700, 0);
            c.ey = $urandom_range(720, c.sy + 1);
            c.ox = $urandom_range(2047, 0);
            c.oy = $urandom_range(2047, 0);
            set_cfg(c);
            commit(1'($urandom_range(1, 0)));
            pend = c;
            chk("rnd.err", cfg_err, 0);
            wait_idle("rnd.blen", 52);
            chk("rnd.pend", cfg_pending, 1);
            exp_sat = (rawq(c.ex - c.sx, c.ox) >= 262144)
                   || (rawq(c.ey - c.sy, c.oy) >= 262144);
            chk("rnd.sat", cfg_sat, exp_sat);
            vs_pulse();
            act = pend;
            act_nn = sh_nn;
            check_active("rnd");
            chk("rnd.start", scaler_start, 1);
            @(negedge clk);
        end

        // Re-commit during DIV_Y; a vsync mid-computation keeps the old frame.
        c = '{100, 50, 900, 650, 799, 599};
        set_cfg(c);
        commit(1'b1);
        repeat (29) @(negedge clk);
        c = '{0, 0, 1280, 720, 639, 359};
        set_cfg(c);
        commit(1'b1);
        pend = c;
        chk("re.busy", cfg_busy, 1);
        vs_pulse();
        chk("re.start", scaler_start, 1);
        check_active("re.old");
        wait_idle("re.blen", 51);
        vs_pulse();
        act = pend;
        act_nn = sh_nn;
        check_active("re.new");
        chk("re.xs_c", x_scale, 32'h8000);

        // Saturation, then a commit coinciding with the swapping vsync.
        c = '{0, 0, 1280, 720, 0, 359};
        set_cfg(c);
        commit(1'b1);
        pend = c;
        wait_idle("sat.blen", 52);
        chk("sat.flag", cfg_sat, 1);
        vs_i      = 1'b1;
        reg_we    = 1'b1;
        reg_addr  = 3'd3;
        reg_wdata = 32'h7;
        @(negedge clk);
        reg_we = 1'b0;
        vs_i   = 1'b0;
        act = pend;
        act_nn = 1'b1;
        check_active("sat");
        chk("sat.xs_c", x_scale, 32'h3FFFF);
        chk("sat.start", scaler_start, 1);
        chk("sat.busy", cfg_busy, 1);
        chk("sat.pend", cfg_pending, 0);
        chk("sat.clr", cfg_sat, 0);

        // Reset in the middle of a division.
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        act = dflt;
        act_nn = 1'b1;
        check_active("mrst");
        chk("mrst.busy", cfg_busy, 0);
        chk("mrst.pend", cfg_pending, 0);
        chk("mrst.err", cfg_err, 0);
        repeat (60) @(negedge clk);
        chk("mrst.lost", cfg_pending, 0);
        vs_pulse();
        chk("mrst.nostart", scaler_start, 0);
        rd(3'd4, d);
        chk("mrst.status", d, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
